// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle stage sequencer for the Y86-64 SEQ core.
// Steps fetch/decode/execute/memory/writeback/PC-update one stage per cycle
// with Moore strobes, owns the condition codes and processor status, and
// counts retired instructions.
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   start              leave IDLE and begin fetching
//   icode              instruction code from fetch, held through PCUPD
//   instr_valid        fetch decoded a legal icode/ifun
//   imem_error         instruction-memory address error
//   alu_flags          {OF,SF,ZF} from execute for the current OPq
//   mem_ready          data memory finished the access this cycle
//   dmem_error         data-memory address error (valid with mem_ready)
//   fetch_en .. pc_en  stage strobes, one per stage state
//   cc                 condition codes {OF,SF,ZF} to execute
//   stat               1=AOK 2=HLT 3=ADR 4=INS
//   busy               instruction in flight
//   retired            completed-instruction count (wraps)
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start
// FETCH     | fetch strobe; classify errors / halt
// DECODE    | decode strobe
// EXECUTE   | execute strobe; OPq loads cc
// MEMORY    | data access pending, bounded by timeout timer
// WRITEBACK | register-file write strobe
// PCUPD     | PC update strobe; instruction retires
// HALT      | halt executed; terminal until reset
// ERR       | address or instruction error; terminal until reset

module seq_stage_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic [2:0]       alu_flags,
   input  logic             mem_ready,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             pc_en,
   output logic [2:0]       cc,
   output logic [2:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] IC_HALT = 4'h0;
   localparam logic [3:0] IC_OPQ  = 4'h6;

   // Down-counter loaded on MEMORY entry; reaching zero with no ready marks
   // the last permitted wait cycle.
   localparam int             TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEMORY,
      ST_WRITEBACK,
      ST_PCUPD,
      ST_HALT,
      ST_ERR
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] tmr;
   logic             tmr_load;
   logic             cc_load;
   logic             retire;
   logic             stat_load;
   logic [2:0]       stat_nxt;
   logic             is_mem_op;

   // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
   always_comb begin
      is_mem_op = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      cc_load   = 1'b0;
      retire    = 1'b0;
      stat_load = 1'b0;
      stat_nxt  = stat;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_error) begin
               state_nxt = ST_ERR;
               stat_load = 1'b1;
               stat_nxt  = STAT_ADR;
            end else if (!instr_valid) begin
               state_nxt = ST_ERR;
               stat_load = 1'b1;
               stat_nxt  = STAT_INS;
            end else if (icode == IC_HALT) begin
               state_nxt = ST_HALT;
               stat_load = 1'b1;
               stat_nxt  = STAT_HLT;
               retire    = 1'b1;
            end else begin
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: state_nxt = ST_EXECUTE;
         ST_EXECUTE: begin
            cc_load = (icode == IC_OPQ);
            if (is_mem_op) begin
               state_nxt = ST_MEMORY;
               tmr_load  = 1'b1;
            end else begin
               state_nxt = ST_WRITEBACK;
            end
         end
         ST_MEMORY: begin
            if (mem_ready) begin
               if (dmem_error) begin
                  state_nxt = ST_ERR;
                  stat_load = 1'b1;
                  stat_nxt  = STAT_ADR;
               end else begin
                  state_nxt = ST_WRITEBACK;
               end
            end else if (tmr == '0) begin
               state_nxt = ST_ERR;
               stat_load = 1'b1;
               stat_nxt  = STAT_ADR;
            end
         end
         ST_WRITEBACK: state_nxt = ST_PCUPD;
         ST_PCUPD: begin
            retire    = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_HALT:  state_nxt = ST_HALT;
         ST_ERR:   state_nxt = ST_ERR;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      fetch_en  = (state == ST_FETCH);
      decode_en = (state == ST_DECODE);
      exec_en   = (state == ST_EXECUTE);
      mem_en    = (state == ST_MEMORY);
      wb_en     = (state == ST_WRITEBACK);
      pc_en     = (state == ST_PCUPD);
      busy      = fetch_en | decode_en | exec_en | mem_en | wb_en | pc_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tmr     <= '0;
         cc      <= 3'b001;
         stat    <= STAT_AOK;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (tmr_load) begin
            tmr <= TMR_LOAD;
         end else if ((state == ST_MEMORY) && !mem_ready && (tmr != '0)) begin
            tmr <= tmr - 1'b1;
         end
         if (cc_load)   cc      <= alu_flags;
         if (stat_load) stat    <= stat_nxt;
         if (retire)    retired <= retired + 1'b1;
      end
   end

endmodule
